// File: rtl/sp_wb_narrow_bridge_if.sv
// Wishbone classic bus bundle, shared by the wide and narrow sides of the bridge.
// Vectors are big-endian (bit 0 is the most significant).
interface sp_wb_narrow_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
);
  logic [0:AW-1] adr;
  logic [0:DW-1] dat_w;
  logic [0:DW-1] dat_r;
  logic          we;
  logic [0:SW-1] sel;
  logic          stb;
  logic          cyc;
  logic          ack;
  logic          err;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err
  );
endinterface

// File: rtl/sp_wb_narrow_bridge.sv
// Splits 32-bit Wishbone accesses in an 8-bit window into narrow beats,
// assembles read lanes, and reports slave errors or per-beat timeouts.
module sp_wb_narrow_bridge #(
  parameter int          NARROW_W   = 8,
  parameter int          ADDR_W     = 24,
  parameter logic [7:0]  WIN_BASE   = 8'h80,
  parameter bit          SKIP_UNSEL = 1'b1,
  parameter int          TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  sp_wb_narrow_bridge_if.slave  s,
  sp_wb_narrow_bridge_if.master m
);
  localparam int BEATS = 32 / NARROW_W;
  localparam int NSEL  = NARROW_W / 8;
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:31]   rdata_q, rdata_d;

  logic             hit;
  logic             act;
  logic             tmo;
  logic             any_sel;
  logic [BEATS-1:0] beat_used;
  logic [1:0]       first_beat;
  logic [1:0]       next_beat;
  logic             has_next;
  int               beat_i;
  logic [ADDR_W-1:0] base;

  assign act     = s.cyc & s.stb;
  assign hit     = act & (s.adr[0:7] == WIN_BASE);
  assign any_sel = |s.sel;
  assign beat_i  = int'(beat_q);

  always_comb begin
    beat_used = '0;
    for (int b = 0; b < BEATS; b++) begin
      beat_used[b] = |s.sel[b*NSEL +: NSEL];
    end
  end

  // Lowest eligible beat, and the next eligible one after the current beat.
  always_comb begin
    first_beat = 2'd0;
    next_beat  = beat_q;
    has_next   = 1'b0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (!SKIP_UNSEL || beat_used[b]) begin
        first_beat = 2'(b);
        if (b > beat_i) begin
          next_beat = 2'(b);
          has_next  = 1'b1;
        end
      end
    end
  end

  assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))
             && !m.ack && !m.err;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          if (SKIP_UNSEL && !any_sel) begin
            state_d = RESP;
            err_d   = 1'b0;
          end else begin
            state_d = BEAT;
            beat_d  = first_beat;
            cnt_d   = '0;
            rdata_d = '0;
          end
        end
      end
      BEAT: begin
        if (!act) begin
          state_d = IDLE;
          beat_d  = 2'd0;
          cnt_d   = '0;
        end else if (m.err || tmo) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (m.ack) begin
          if (!s.we) begin
            rdata_d[beat_i*NARROW_W +: NARROW_W] = m.dat_r;
          end
          if (has_next) begin
            beat_d = next_beat;
            cnt_d  = '0;
          end else begin
            state_d = RESP;
            err_d   = 1'b0;
          end
        end else if (cnt_q != CW'(TIMEOUT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        beat_d  = 2'd0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Handshake outputs are gated by reset so they drop in the reset cycle.
  assign s.ack   = !reset && (state_q == RESP) && !err_q;
  assign s.err   = !reset && (state_q == RESP) && err_q;
  assign s.dat_r = rdata_q;

  assign base    = {s.adr[32-ADDR_W:29], 2'b00};
  assign m.adr   = base + ADDR_W'(beat_i * NSEL);
  assign m.dat_w = s.dat_w[beat_i*NARROW_W +: NARROW_W];
  assign m.we    = s.we;
  assign m.stb   = !reset && (state_q == BEAT) && act;
  assign m.cyc   = m.stb;
  assign m.sel   = (!reset && state_q == BEAT)
                 ? s.sel[beat_i*NSEL +: NSEL] : '0;
endmodule

// File: tb/tb_sp_wb_narrow_bridge.sv
// Directed bench: 8-bit bridge (skip, timeout 8) and 16-bit bridge
// against small combinational narrow slaves.
module tb_sp_wb_narrow_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sp_wb_narrow_bridge_if #(.AW(32), .DW(32), .SW(4)) ws8 ();
  sp_wb_narrow_bridge_if #(.AW(24), .DW(8),  .SW(1)) nb8 ();
  sp_wb_narrow_bridge_if #(.AW(32), .DW(32), .SW(4)) ws16 ();
  sp_wb_narrow_bridge_if #(.AW(24), .DW(16), .SW(2)) nb16 ();

  sp_wb_narrow_bridge #(
    .NARROW_W(8), .ADDR_W(24), .WIN_BASE(8'h80),
    .SKIP_UNSEL(1'b1), .TIMEOUT(8)
  ) dut8 (
    .clk(clk), .reset(reset), .s(ws8.slave), .m(nb8.master)
  );

  sp_wb_narrow_bridge #(
    .NARROW_W(16), .ADDR_W(24), .WIN_BASE(8'h80),
    .SKIP_UNSEL(1'b1), .TIMEOUT(255)
  ) dut16 (
    .clk(clk), .reset(reset), .s(ws16.slave), .m(nb16.master)
  );

  logic [7:0] rd8 [4];
  logic       ack_en8 = 1'b1;
  logic       err_en8 = 1'b0;
  logic [1:0] err_beat = 2'd0;

  assign nb8.dat_r = rd8[nb8.adr[22:23]];
  assign nb8.err   = nb8.stb & err_en8 & (nb8.adr[22:23] == err_beat);
  assign nb8.ack   = nb8.stb & ack_en8 & !nb8.err;

  assign nb16.dat_r = nb16.adr[22] ? 16'h5566 : 16'h7788;
  assign nb16.ack   = nb16.stb;
  assign nb16.err   = 1'b0;

  int total = 0;
  int bad = 0;

  int          nbeat;
  int          ack_cyc;
  int          err_cyc;
  int          stray;
  logic [23:0] lg_adr [16];
  logic [15:0] lg_dat [16];
  logic [1:0]  lg_sel [16];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w16, input logic [31:0] adr,
                       input logic [31:0] dat, input logic we,
                       input logic [3:0] sel, input logic on);
    if (w16) begin
      ws16.adr = adr; ws16.dat_w = dat; ws16.we = we;
      ws16.sel = sel; ws16.cyc = on; ws16.stb = on;
    end else begin
      ws8.adr = adr; ws8.dat_w = dat; ws8.we = we;
      ws8.sel = sel; ws8.cyc = on; ws8.stb = on;
    end
  endtask

  // Request applied before the edge of cycle 0; cycle c observed #1 after edge c-1.
  task automatic xfer(input bit w16, input logic [31:0] adr,
                      input logic [31:0] dat, input logic we,
                      input logic [3:0] sel, input int maxc);
    logic s_stb, s_ack, s_err;
    @(negedge clk);
    drive(w16, adr, dat, we, sel, 1'b1);
    nbeat = 0; ack_cyc = -1; err_cyc = -1; stray = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk); #1;
      s_stb = w16 ? nb16.stb : nb8.stb;
      s_ack = w16 ? ws16.ack : ws8.ack;
      s_err = w16 ? ws16.err : ws8.err;
      if (s_stb && nbeat < 16) begin
        lg_adr[nbeat] = w16 ? nb16.adr : nb8.adr;
        lg_dat[nbeat] = w16 ? nb16.dat_w : {8'h00, nb8.dat_w};
        lg_sel[nbeat] = w16 ? nb16.sel : {1'b0, nb8.sel};
      end
      if (s_stb) nbeat++;
      if (s_ack) ack_cyc = c;
      if (s_err) err_cyc = c;
      if (s_ack || s_err) break;
    end
    @(negedge clk);
    drive(w16, adr, dat, we, sel, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (w16 ? (nb16.stb | ws16.ack | ws16.err)
              : (nb8.stb | ws8.ack | ws8.err)) stray++;
    end
  endtask

  initial begin
    rd8[0] = 8'h11; rd8[1] = 8'h22; rd8[2] = 8'h33; rd8[3] = 8'h44;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ws8.ack}, 32'd0);
    check("rst_stb", {31'd0, nb8.stb}, 32'd0);
    check("rst_dat", ws8.dat_r, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // T1: full 4-beat read, zero-wait slave
    xfer(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'hF, 20);
    check("t1_nbeat", nbeat, 4);
    check("t1_adr0", {8'h0, lg_adr[0]}, 32'h0000_1234);
    check("t1_adr3", {8'h0, lg_adr[3]}, 32'h0000_1237);
    check("t1_ackc", ack_cyc, 5);
    check("t1_dat", ws8.dat_r, 32'h1122_3344);
    check("t1_stray", stray, 0);

    // T2: 16-bit write, 2 beats
    xfer(1'b1, 32'h8000_0010, 32'hAABB_CCDD, 1'b1, 4'hF, 20);
    check("t2_nbeat", nbeat, 2);
    check("t2_adr0", {8'h0, lg_adr[0]}, 32'h0000_0010);
    check("t2_dat0", {16'h0, lg_dat[0]}, 32'h0000_AABB);
    check("t2_sel0", {30'h0, lg_sel[0]}, 32'd3);
    check("t2_adr1", {8'h0, lg_adr[1]}, 32'h0000_0012);
    check("t2_dat1", {16'h0, lg_dat[1]}, 32'h0000_CCDD);
    check("t2_ackc", ack_cyc, 3);

    // 16-bit read of lanes 2,3 only: lower half skipped
    xfer(1'b1, 32'h8000_0010, 32'h0, 1'b0, 4'b0011, 20);
    check("t2r_nbeat", nbeat, 1);
    check("t2r_adr", {8'h0, lg_adr[0]}, 32'h0000_0012);
    check("t2r_dat", ws16.dat_r, 32'h0000_5566);
    check("t2r_ackc", ack_cyc, 2);

    // T3: lane 1 only -> single beat at +1
    xfer(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'b0100, 20);
    check("t3_nbeat", nbeat, 1);
    check("t3_adr", {8'h0, lg_adr[0]}, 32'h0000_1235);
    check("t3_dat", ws8.dat_r, 32'h0022_0000);
    check("t3_ackc", ack_cyc, 2);

    // lanes 0 and 3
    xfer(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'b1001, 20);
    check("t3b_nbeat", nbeat, 2);
    check("t3b_adr1", {8'h0, lg_adr[1]}, 32'h0000_1237);
    check("t3b_dat", ws8.dat_r, 32'h1100_0044);
    check("t3b_ackc", ack_cyc, 3);

    // no lanes -> immediate ack
    xfer(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'h0, 20);
    check("t3z_nbeat", nbeat, 0);
    check("t3z_ackc", ack_cyc, 1);

    // T4: error on beat 2
    err_en8 = 1'b1; err_beat = 2'd2;
    xfer(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'hF, 20);
    err_en8 = 1'b0;
    check("t4_nbeat", nbeat, 3);
    check("t4_errc", err_cyc, 4);
    check("t4_ackc", ack_cyc, -1);
    check("t4_dat", ws8.dat_r, 32'h1122_0000);
    check("t4_stray", stray, 0);

    // silent slave -> timeout after 8 cycles in beat 0
    ack_en8 = 1'b0;
    xfer(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'hF, 20);
    check("t4t_nbeat", nbeat, 8);
    check("t4t_errc", err_cyc, 9);
    check("t4t_ackc", ack_cyc, -1);
    check("t4t_dat", ws8.dat_r, 32'h0);
    ack_en8 = 1'b1;

    // T5: abort during beat 1
    @(negedge clk);
    drive(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'hF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_stb_b1", {31'd0, nb8.stb}, 32'd1);
    @(negedge clk);
    ws8.cyc = 1'b0;
    #1;
    check("t5_stb_drop", {31'd0, nb8.stb}, 32'd0);
    @(negedge clk);
    ws8.stb = 1'b0;
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (nb8.stb | ws8.ack | ws8.err) stray++;
    end
    check("t5_stray", stray, 0);
    check("t5_dat", ws8.dat_r, 32'h1100_0000);
    xfer(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'hF, 20);
    check("t5_ackc", ack_cyc, 5);
    check("t5_rdat", ws8.dat_r, 32'h1122_3344);

    // T6: reset mid-beat with a stalled slave
    ack_en8 = 1'b0;
    @(negedge clk);
    drive(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'hF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_stb_pre", {31'd0, nb8.stb}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_stb_rst", {31'd0, nb8.stb}, 32'd0);
    check("t6_sel_rst", {31'd0, nb8.sel}, 32'd0);
    @(posedge clk); #1;
    check("t6_cyc", {31'd0, nb8.cyc}, 32'd0);
    check("t6_ack", {30'd0, ws8.ack, ws8.err}, 32'd0);
    check("t6_dat", ws8.dat_r, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h8000_1234, 32'h0, 1'b0, 4'hF, 1'b0);
    reset = 1'b0;
    ack_en8 = 1'b1;

    // outside the window: nothing happens
    xfer(1'b0, 32'hFF00_1234, 32'h0, 1'b0, 4'hF, 8);
    check("t6w_nbeat", nbeat, 0);
    check("t6w_ackc", ack_cyc, -1);
    check("t6w_errc", err_cyc, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
